mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the fetch stage (instruction reads) and the MEM stage (lw/sw data accesses) of the pipelined MIPS core.
- Arbitrates between the two requesters, sequences each access through issue, wait and response, and drives per-requester stall outputs into the hazard logic.
- Data requests have priority, with a fairness limit so fetch cannot starve.

Parameters:
- MEM_LATENCY, 2, cycles from the issue cycle to the cycle in which mem_rdata is valid; legal range ≥1.
- FAIR_LIMIT, 2, maximum consecutive data grants while if_req is pending; legal range ≥1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_read  in  1  data read request (lw).
- d_write  in  1  data write request (sw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  equals if_req & ~if_ready.
- stall_mem  out  1  equals (d_read | d_write) & ~d_ready.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- Reset (synchronous, rst=1):
  - State goes to IDLE.
  - Latency counter, fairness counter and grant register clear to 0.
  - if_rdata and d_rdata clear to 0.
  - if_ready, d_ready, mem_en and mem_we are 0.
  - Reset takes effect from any state; an in-flight access is abandoned and no ready pulse is produced for it.
  - Requests present while rst=1 are ignored.
- IDLE, arbitration:
  - Data request present, and not (if_req and fair_cnt==FAIR_LIMIT): grant data.
  - Otherwise, if_req present: grant fetch.
  - On a grant, latch the grant, address, we (=d_write) and wdata, then go to ISSUE.
  - d_read and d_write together is illegal; it is treated as a write.
- Fairness counter:
  - Increments on a data grant made while if_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant made while if_req=0.
- ISSUE (exactly one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Load counter with MEM_LATENCY, then go to WAIT.
  - mem_en and mem_we are 0 in every state other than ISSUE.
  - mem_addr and mem_wdata hold their last values outside ISSUE.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter==1, mem_rdata is valid. On that edge, capture mem_rdata into the granted requester's rdata register (reads only; writes leave d_rdata unchanged), then go to RESP.
  - WAIT therefore lasts MEM_LATENCY cycles.
- RESP (one cycle):
  - Pulse the granted requester's ready, then go to IDLE.
  - No arbitration happens in RESP. This prevents the still-asserted request from being re-granted.
- Latency and throughput:
  - A request seen in IDLE at cycle 0 gets its ready pulse at cycle MEM_LATENCY+2.
  - Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- Requester protocol:
  - A requester holds its request and operands stable until its ready pulse.
  - If a request is dropped early, the latched access still completes and ready still pulses.
- The rdata registers hold their value until the next capture for the same requester.

Test Plan:
- Fetch read (MEM_LATENCY=2):
  - Stimulus: if_req=1, if_addr=0x40 at cycle 0; mem_rdata=0x8C220004 in cycle 3.
  - Required: mem_en=1 and mem_addr=0x40 in cycle 1 only; if_ready=1 and if_rdata=0x8C220004 in cycle 4; stall_if=1 in cycles 0–3 and 0 in cycle 4; busy=1 in cycles 1–4.
- Simultaneous requests in IDLE:
  - Stimulus: if_req=1 and d_read=1 with d_addr=0x100 at cycle 0.
  - Required: memory issues 0x100 first and d_ready pulses at cycle 4; the fetch issues at cycle 6 and if_ready pulses at cycle 9; stall_if stays 1 throughout cycles 0–8.
- Starvation bound:
  - Stimulus: if_req and d_read held high continuously, FAIR_LIMIT=2.
  - Required: grant order D,D,I,D,D,I.
- Store:
  - Stimulus: d_write=1, d_addr=0x24, d_wdata=0xDEADBEEF.
  - Required: mem_en=1, mem_we=1, mem_addr=0x24, mem_wdata=0xDEADBEEF in the ISSUE cycle only; d_ready pulses; d_rdata unchanged.
- Reset mid-WAIT:
  - Stimulus: assert rst for one cycle during WAIT of a fetch.
  - Required: next cycle is IDLE with busy=0; no if_ready pulse for the abandoned access; if_rdata=0; a new request afterwards completes normally.
- Corner cases:
  - MEM_LATENCY=1: latency is 3 cycles.
  - d_read and d_write together: the access is performed as a write.
  - d_read dropped during WAIT: d_ready still pulses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch stage and the MEM stage.
// Data accesses win arbitration unless fetch has already been passed over
// FAIR_LIMIT times in a row. Every access goes IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int FAIR_LIMIT  = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [FAIR_W-1:0] fair_reg;
  logic              gnt_data_reg;  // 1: current access belongs to the MEM stage
  logic              we_reg;        // current access is a store

  logic d_req;
  logic fair_block;
  logic grant_d;
  logic grant_i;

  // Arbitration: data first, unless fetch has waited through FAIR_LIMIT data grants.
  assign d_req      = d_read | d_write;
  assign fair_block = if_req && (fair_reg == FAIR_MAX);
  assign grant_d    = d_req && !fair_block;
  assign grant_i    = !grant_d && if_req;

  assign busy      = (state_reg != IDLE);
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  // Access sequencer: grant, issue strobe, latency count, capture and ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      fair_reg     <= '0;
      gnt_data_reg <= 1'b0;
      we_reg       <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_ready     <= 1'b0;
      d_ready      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      // Strobes and ready pulses last exactly one cycle.
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d || grant_i) begin
            gnt_data_reg <= grant_d;
            // A simultaneous read and write is carried out as a write.
            we_reg       <= grant_d & d_write;
            mem_en       <= 1'b1;
            mem_we       <= grant_d & d_write;
            mem_addr     <= grant_d ? d_addr : if_addr;
            mem_wdata    <= d_wdata;
            state_reg    <= ISSUE;
            if (grant_d && if_req) begin
              fair_reg <= fair_reg + FAIR_W'(1);
            end else begin
              fair_reg <= '0;
            end
          end
        end
        ISSUE: begin
          cnt_reg   <= LAT_LOAD;
          state_reg <= WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            if (!we_reg) begin
              if (gnt_data_reg) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (gnt_data_reg) begin
              d_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
            state_reg <= RESP;
          end
        end
        RESP: begin
          // No arbitration here, so a request still held high is not granted twice.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expectations are queued when a request
// is driven and popped when the matching ready pulse appears.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (MEM_LATENCY=2, FAIR_LIMIT=2)
  logic        if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;

  // Second instance (MEM_LATENCY=1)
  logic        if_req_1, d_read_1, d_write_1;
  logic [31:0] if_addr_1, d_addr_1, d_wdata_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        if_ready_1, d_ready_1, mem_en_1, mem_we_1, stall_if_1, stall_mem_1, busy_1;

  mem_port_arbiter #(.MEM_LATENCY(2), .FAIR_LIMIT(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .FAIR_LIMIT(2), .ADDR_W(32), .DATA_W(32)) u_dut_1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
    .d_read(d_read_1), .d_write(d_write_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_rdata(d_rdata_1), .d_ready(d_ready_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .stall_if(stall_if_1), .stall_mem(stall_mem_1), .busy(busy_1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- memory models ----------------
  bit          wr_valid [0:255];
  logic [31:0] wr_data  [0:255];
  logic [1:0]  pv;
  logic [31:0] pa [0:1];
  logic        pv_1;
  logic [31:0] pa_1;

  function automatic logic [31:0] base_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C220004 : (a ^ 32'h5A5A0000);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return wr_valid[a[9:2]] ? wr_data[a[9:2]] : base_word(a);
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[0], mem_en & ~mem_we};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    if (mem_en && mem_we) begin
      wr_valid[mem_addr[9:2]] <= 1'b1;
      wr_data[mem_addr[9:2]]  <= mem_wdata;
    end
    pv_1 <= mem_en_1 & ~mem_we_1;
    pa_1 <= mem_addr_1;
  end

  assign mem_rdata   = pv[1] ? mem_word(pa[1]) : 32'hBAD0BAD0;
  assign mem_rdata_1 = pv_1  ? base_word(pa_1) : 32'hBAD0BAD0;

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] data; int cyc; } exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } iss_t;

  exp_t if_q[$];
  exp_t d_q[$];
  iss_t issue_q[$];
  exp_t mon_e;
  logic [31:0] last_d = 32'h0;

  always @(negedge clk) begin
    if (if_ready) begin
      if (if_q.size() == 0) check("if_ready_unexpected", 32'(1), 32'(0));
      else begin
        mon_e = if_q.pop_front();
        check("if_rdata", if_rdata, mon_e.data);
        check("if_ready_cycle", cyc, mon_e.cyc);
      end
    end
    if (d_ready) begin
      if (d_q.size() == 0) check("d_ready_unexpected", 32'(1), 32'(0));
      else begin
        mon_e = d_q.pop_front();
        check("d_rdata", d_rdata, mon_e.data);
        check("d_ready_cycle", cyc, mon_e.cyc);
      end
    end
    if (mem_en) issue_q.push_back('{mem_we, mem_addr, mem_wdata, cyc});
    if (mem_we && !mem_en) check("mem_we_outside_issue", 32'(1), 32'(0));
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    int c0 = cyc;
    issue_q.delete();
    if_req  = 1'b1;
    if_addr = addr;
    if_q.push_back('{mem_word(addr), c0 + 4});
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("fetch_stall_if", 32'(stall_if), 32'(k < 4));
      check("fetch_busy", 32'(busy), 32'(k >= 1));
      check("fetch_mem_en", 32'(mem_en), 32'(k == 1));
      if (k == 1) check("fetch_mem_addr", mem_addr, addr);
      step();
    end
    if_req = 1'b0;
    check("fetch_issue_count", issue_q.size(), 32'(1));
  endtask

  task automatic data_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int drop_at);
    int c0 = cyc;
    issue_q.delete();
    d_read  = rd;
    d_write = wr;
    d_addr  = addr;
    d_wdata = wdata;
    if (!wr) last_d = mem_word(addr);
    d_q.push_back('{last_d, c0 + 4});
    for (int k = 0; k < 5; k++) begin
      step();
      if (k + 1 == drop_at) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
    end
    d_read  = 1'b0;
    d_write = 1'b0;
    check("dop_issue_count", issue_q.size(), 32'(1));
    if (issue_q.size() == 1) begin
      check("dop_we", 32'(issue_q[0].we), 32'(wr));
      check("dop_addr", issue_q[0].addr, addr);
      check("dop_issue_cycle", issue_q[0].cyc, c0 + 1);
      if (wr) check("dop_wdata", issue_q[0].wdata, wdata);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    rst = 1'b1;
    if_req = 0; d_read = 0; d_write = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req_1 = 0; d_read_1 = 0; d_write_1 = 0; if_addr_1 = 0; d_addr_1 = 0; d_wdata_1 = 0;
    step(); step();
    // Requests during reset are ignored
    if_req = 1'b1;
    d_read = 1'b1;
    @(negedge clk);
    check("busy_in_reset", 32'(busy), 32'(0));
    step();
    @(negedge clk);
    check("busy_in_reset_2", 32'(busy), 32'(0));
    step();
    rst = 1'b0;
    if_req = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_mem_en", 32'(mem_en), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_if_ready", 32'(if_ready), 32'(0));
    check("rst_d_ready", 32'(d_ready), 32'(0));
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    step();

    // Fetch read
    do_fetch(32'h40);
    wait_idle();

    // Simultaneous requests: data first, fetch issues at cycle 6
    c0 = cyc;
    issue_q.delete();
    if_req = 1'b1; if_addr = 32'h44;
    d_read = 1'b1; d_addr = 32'h100;
    last_d = mem_word(32'h100);
    d_q.push_back('{last_d, c0 + 4});
    if_q.push_back('{mem_word(32'h44), c0 + 9});
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check("sim_stall_if", 32'(stall_if), 32'(k < 9));
      if (k <= 4) check("sim_stall_mem", 32'(stall_mem), 32'(k < 4));
      step();
      if (k == 4) d_read = 1'b0;
    end
    if_req = 1'b0;
    check("sim_issue_count", issue_q.size(), 32'(2));
    if (issue_q.size() == 2) begin
      check("sim_first_addr", issue_q[0].addr, 32'h100);
      check("sim_first_cycle", issue_q[0].cyc, c0 + 1);
      check("sim_second_addr", issue_q[1].addr, 32'h44);
      check("sim_second_cycle", issue_q[1].cyc, c0 + 6);
    end
    wait_idle();

    // Starvation bound: D,D,I,D,D,I
    c0 = cyc;
    issue_q.delete();
    if_req = 1'b1; if_addr = 32'h80;
    d_read = 1'b1; d_addr = 32'h200;
    last_d = mem_word(32'h200);
    for (int s = 0; s < 6; s++) begin
      if (s % 3 == 2) if_q.push_back('{mem_word(32'h80), c0 + 4 + 5 * s});
      else            d_q.push_back('{last_d, c0 + 4 + 5 * s});
    end
    repeat (30) step();
    if_req = 1'b0;
    d_read = 1'b0;
    check("fair_issue_count", issue_q.size(), 32'(6));
    for (int s = 0; s < 6 && s < issue_q.size(); s++) begin
      check($sformatf("fair_slot%0d_addr", s), issue_q[s].addr,
            (s % 3 == 2) ? 32'h80 : 32'h200);
      check($sformatf("fair_slot%0d_cycle", s), issue_q[s].cyc, c0 + 1 + 5 * s);
    end
    wait_idle();

    // Store, read+write together (acts as write), read-back, read dropped in WAIT
    data_op(1'b0, 1'b1, 32'h24, 32'hDEADBEEF, 5);
    wait_idle();
    data_op(1'b1, 1'b1, 32'h28, 32'h12345678, 5);
    wait_idle();
    data_op(1'b1, 1'b0, 32'h28, 32'h0, 5);
    check("readback_value", last_d, 32'h12345678);
    wait_idle();
    data_op(1'b1, 1'b0, 32'h300, 32'h0, 2);
    wait_idle();

    // Reset during WAIT of a fetch
    if_req = 1'b1; if_addr = 32'h48;
    step(); step();
    rst = 1'b1;
    if_req = 1'b0;
    step();
    rst = 1'b0;
    last_d = 32'h0;
    @(negedge clk);
    check("rstw_busy", 32'(busy), 32'(0));
    check("rstw_if_rdata", if_rdata, 32'h0);
    check("rstw_d_rdata", d_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstw_no_if_ready", 32'(if_ready), 32'(0));
    end
    step();
    do_fetch(32'h40);
    wait_idle();

    // MEM_LATENCY=1 instance: three-cycle latency for fetch and load
    if_req_1 = 1'b1; if_addr_1 = 32'h40;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("l1_fetch_mem_en", 32'(mem_en_1), 32'(k == 1));
      check("l1_if_ready", 32'(if_ready_1), 32'(k == 3));
      if (k == 3) check("l1_if_rdata", if_rdata_1, 32'h8C220004);
      step();
    end
    if_req_1 = 1'b0;
    step();
    d_read_1 = 1'b1; d_addr_1 = 32'h60;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      check("l1_d_ready", 32'(d_ready_1), 32'(k == 3));
      if (k == 3) check("l1_d_rdata", d_rdata_1, base_word(32'h60));
      step();
    end
    d_read_1 = 1'b0;
    step(); step();

    check("if_q_left", if_q.size(), 32'(0));
    check("d_q_left", d_q.size(), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
